// File: rtl/cim_seq_controller.sv
// Command queue and phase sequencer for a compute-in-memory array: pops queued
// commands and drives the read/write wordlines of each execution step.
module cim_seq_controller #(
  parameter int COL_NUM         = 64,
  parameter int COL_BITS        = 6,
  parameter int CMD_DEPTH       = 4,
  parameter int ZERO_ADDR       = 0,
  parameter int SUM_PIPO_ADDR   = COL_NUM - 2,
  parameter int BOOTH_PIPO_ADDR = COL_NUM - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [24:0]        cmd,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [COL_NUM-1:0] rwl_ch1,
  output logic [COL_NUM-1:0] rwl_ch2,
  output logic [COL_NUM-1:0] rwl_ch3,
  output logic [COL_NUM-1:0] wwl_ch1,
  output logic [COL_NUM-1:0] wwl_ch2,
  output logic [4:0]         cur_iter
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] MODE_AND   = 3'd1;
  localparam logic [2:0] MODE_XOR   = 3'd2;
  localparam logic [2:0] MODE_SHIFT = 3'd3;
  localparam logic [2:0] MODE_ADD   = 3'd4;
  localparam logic [2:0] MODE_SUB   = 3'd5;
  localparam logic [2:0] MODE_MUL   = 3'd6;

  localparam logic [COL_BITS-1:0] ZERO_A  = COL_BITS'(ZERO_ADDR);
  localparam logic [COL_BITS-1:0] SUM_A   = COL_BITS'(SUM_PIPO_ADDR);
  localparam logic [COL_BITS-1:0] BOOTH_A = COL_BITS'(BOOTH_PIPO_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC} state_t;

  logic [24:0]      queue_mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             q_empty;
  logic [24:0]      head;

  state_t           state;
  logic [24:0]      cmd_reg;
  logic [4:0]       iter;
  logic [4:0]       last_iter;
  logic [4:0]       nk;
  logic             exec_last;

  logic [2:0]          mode;
  logic [2:0]          len;
  logic [COL_BITS-1:0] rs1;
  logic [COL_BITS-1:0] rs2;
  logic [COL_BITS-1:0] rd;
  logic                special_unused;

  logic                en_r1, en_r2, en_r3, en_w1, en_w2;
  logic [COL_BITS-1:0] a_r1, a_r2, a_r3, a_w1, a_w2;

  function automatic logic is_legal(input logic [24:0] c);
    logic mode_ok;
    logic len_ok;
    mode_ok  = (c[23:21] != 3'd0) && (c[23:21] != 3'd7);
    len_ok   = (c[20:18] >= 3'd1) && (c[20:18] <= 3'd5);
    is_legal = mode_ok && ((c[23:21] != MODE_MUL) || len_ok);
  endfunction

  function automatic logic [COL_NUM-1:0] one_hot(input logic en, input logic [COL_BITS-1:0] a);
    one_hot = '0;
    if (en) one_hot[a] = 1'b1;
  endfunction

  assign q_empty   = (count == '0);
  assign cmd_ready = (count != CNT_W'(CMD_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = queue_mem[rd_ptr];
  assign busy      = !q_empty || (state != IDLE);
  assign cur_iter  = iter;

  assign mode           = cmd_reg[23:21];
  assign len            = cmd_reg[20:18];
  assign rs1            = cmd_reg[12 +: COL_BITS];
  assign rs2            = cmd_reg[6 +: COL_BITS];
  assign rd             = cmd_reg[0 +: COL_BITS];
  assign special_unused = cmd_reg[24];

  always_comb begin
    last_iter = 5'd0;
    if (mode == MODE_MUL) last_iter = 5'((6'd1 << len) - 6'd1);
  end

  assign exec_last = (state == EXEC) && (iter == last_iter);
  assign pop       = !q_empty && ((state == IDLE) || exec_last);
  assign nk        = (state == EXEC) ? iter + 5'd1 : 5'd0;

  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Channel addressing for the step about to be entered (iteration nk).
  always_comb begin
    en_r1 = 1'b0; en_r2 = 1'b0; en_r3 = 1'b0; en_w1 = 1'b0; en_w2 = 1'b0;
    a_r1  = '0;   a_r2  = '0;   a_r3  = '0;   a_w1  = '0;   a_w2  = '0;
    case (mode)
      MODE_AND, MODE_XOR: begin
        en_r1 = 1'b1; a_r1 = rs1;
        en_r2 = 1'b1; a_r2 = rs2;
        en_w1 = 1'b1; a_w1 = rd;
      end
      MODE_SHIFT: begin
        en_r3 = 1'b1; a_r3 = rs1;
        en_w2 = 1'b1; a_w2 = rd;
      end
      MODE_ADD, MODE_SUB: begin
        en_r1 = 1'b1; a_r1 = rs1;
        en_r2 = 1'b1; a_r2 = rs2;
        en_w1 = 1'b1; a_w1 = rd;
        en_r3 = 1'b1; a_r3 = {rs2[COL_BITS-1:1], 1'b1};
        en_w2 = 1'b1; a_w2 = {rd[COL_BITS-1:1], 1'b1};
      end
      MODE_MUL: begin
        en_r1 = 1'b1; en_r2 = 1'b1; en_r3 = 1'b1; en_w1 = 1'b1; en_w2 = 1'b1;
        if (nk == 5'd0)  a_r1 = ZERO_A;
        else if (nk[0])  a_r1 = SUM_A;
        else             a_r1 = rd;
        a_r2 = rs2;
        a_r3 = nk[0] ? BOOTH_A : rs1;
        a_w1 = nk[0] ? rd : SUM_A;
        a_w2 = nk[0] ? rs1 : BOOTH_A;
      end
      default: ;
    endcase
  end

  // The pop happens on the edge entering LOAD, so err is valid during LOAD itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cmd_reg <= '0;
      iter    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rwl_ch1 <= '0;
      rwl_ch2 <= '0;
      rwl_ch3 <= '0;
      wwl_ch1 <= '0;
      wwl_ch2 <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (!q_empty) begin
            state   <= LOAD;
            cmd_reg <= head;
            err     <= !is_legal(head);
          end
        end
        LOAD: begin
          if (is_legal(cmd_reg)) begin
            state   <= EXEC;
            iter    <= 5'd0;
            done    <= (last_iter == 5'd0);
            rwl_ch1 <= one_hot(en_r1, a_r1);
            rwl_ch2 <= one_hot(en_r2, a_r2);
            rwl_ch3 <= one_hot(en_r3, a_r3);
            wwl_ch1 <= one_hot(en_w1, a_w1);
            wwl_ch2 <= one_hot(en_w2, a_w2);
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          if (exec_last) begin
            iter    <= 5'd0;
            rwl_ch1 <= '0;
            rwl_ch2 <= '0;
            rwl_ch3 <= '0;
            wwl_ch1 <= '0;
            wwl_ch2 <= '0;
            if (!q_empty) begin
              state   <= LOAD;
              cmd_reg <= head;
              err     <= !is_legal(head);
            end else begin
              state <= IDLE;
            end
          end else begin
            iter    <= nk;
            done    <= (nk == last_iter);
            rwl_ch1 <= one_hot(en_r1, a_r1);
            rwl_ch2 <= one_hot(en_r2, a_r2);
            rwl_ch3 <= one_hot(en_r3, a_r3);
            wwl_ch1 <= one_hot(en_w1, a_w1);
            wwl_ch2 <= one_hot(en_w2, a_w2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_seq_controller.sv
// Directed bench for cim_seq_controller: steps through hand-timed command
// sequences and asserts outputs on each falling clock edge.
module tb_cim_seq_controller;

  localparam logic [2:0] M_AND = 3'd1, M_XOR = 3'd2, M_SHIFT = 3'd3;
  localparam logic [2:0] M_ADD = 3'd4, M_MUL = 3'd6;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [24:0] cmd;
  logic        busy, done, err;
  logic [63:0] rwl_ch1, rwl_ch2, rwl_ch3, wwl_ch1, wwl_ch2;
  logic [4:0]  cur_iter;

  int checks;
  int errors;

  cim_seq_controller dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .busy(busy), .done(done), .err(err),
    .rwl_ch1(rwl_ch1), .rwl_ch2(rwl_ch2), .rwl_ch3(rwl_ch3),
    .wwl_ch1(wwl_ch1), .wwl_ch2(wwl_ch2), .cur_iter(cur_iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] mk_cmd(input logic [2:0] m, input logic [2:0] l,
                                         input int s1, input int s2, input int d);
    return {1'b0, m, l, 6'(s1), 6'(s2), 6'(d)};
  endfunction

  function automatic logic [63:0] oh(input int a);
    return 64'd1 << a;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [24:0] c);
    cmd_valid = v;
    cmd       = c;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkWordlines(input string tag, input logic [63:0] r1, input logic [63:0] r2,
                                input logic [63:0] r3, input logic [63:0] w1, input logic [63:0] w2);
    checkOutput({tag, "_rwl1"}, rwl_ch1, r1);
    checkOutput({tag, "_rwl2"}, rwl_ch2, r2);
    checkOutput({tag, "_rwl3"}, rwl_ch3, r3);
    checkOutput({tag, "_wwl1"}, wwl_ch1, w1);
    checkOutput({tag, "_wwl2"}, wwl_ch2, w2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    applyStimulus(1'b0, 25'd0);
    #2 rst_n = 1'b0;
    tick();
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_iter", cur_iter, 0);
    checkWordlines("rst", 0, 0, 0, 0, 0);
    tick();

    // MUL with four iterations; the push lands on the first edge after release
    rst_n = 1'b1;
    applyStimulus(1'b1, mk_cmd(M_MUL, 3'd2, 3, 5, 9));
    tick();
    applyStimulus(1'b0, 25'd0);
    checkOutput("mul_first_push", busy, 1);
    tick();
    checkWordlines("mul_load", 0, 0, 0, 0, 0);
    checkOutput("mul_load_err", err, 0);
    tick();
    checkWordlines("mul_k0", oh(0), oh(5), oh(3), oh(62), oh(63));
    checkOutput("mul_k0_iter", cur_iter, 0);
    checkOutput("mul_k0_done", done, 0);
    tick();
    checkWordlines("mul_k1", oh(62), oh(5), oh(63), oh(9), oh(3));
    checkOutput("mul_k1_iter", cur_iter, 1);
    tick();
    checkWordlines("mul_k2", oh(9), oh(5), oh(3), oh(62), oh(63));
    checkOutput("mul_k2_done", done, 0);
    tick();
    checkWordlines("mul_k3", oh(62), oh(5), oh(63), oh(9), oh(3));
    checkOutput("mul_k3_iter", cur_iter, 3);
    checkOutput("mul_k3_done", done, 1);
    tick();
    checkOutput("mul_end_done", done, 0);
    checkOutput("mul_end_busy", busy, 0);
    checkOutput("mul_end_iter", cur_iter, 0);
    checkWordlines("mul_end", 0, 0, 0, 0, 0);

    // Queue full: a long MUL occupies the engine while five ANDs are offered
    applyStimulus(1'b1, mk_cmd(M_MUL, 3'd3, 1, 2, 4));
    for (int i = 0; i < 5; i++) begin
      tick();
      applyStimulus(1'b1, mk_cmd(M_AND, 3'd0, 10 + i, 20 + i, 30 + i));
    end
    checkOutput("full_ready_low", cmd_ready, 0);
    checkOutput("full_busy", busy, 1);
    repeat (5) tick();
    checkOutput("full_mul_done", done, 1);
    checkOutput("full_ready_held", cmd_ready, 0);
    tick();
    checkOutput("full_ready_back", cmd_ready, 1);
    checkWordlines("full_load0", 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1'b0, 25'd0);
    checkOutput("full_ready_refill", cmd_ready, 0);
    checkWordlines("full_and0", oh(10), oh(20), 0, oh(30), 0);
    checkOutput("full_and0_done", done, 1);
    for (int i = 1; i < 5; i++) begin
      tick();
      checkOutput("full_load_rwl1", rwl_ch1, 0);
      checkOutput("full_load_done", done, 0);
      tick();
      checkOutput("full_and_rwl1", rwl_ch1, oh(10 + i));
      checkOutput("full_and_wwl1", wwl_ch1, oh(30 + i));
      checkOutput("full_and_done", done, 1);
    end
    tick();
    checkOutput("full_end_busy", busy, 0);
    checkOutput("full_end_ready", cmd_ready, 1);

    // Illegal mode 7, illegal MUL length 6, then a legal XOR
    applyStimulus(1'b1, mk_cmd(3'd7, 3'd0, 1, 1, 1));
    tick();
    applyStimulus(1'b1, mk_cmd(M_MUL, 3'd6, 2, 2, 2));
    tick();
    applyStimulus(1'b1, mk_cmd(M_XOR, 3'd7, 7, 8, 12));
    checkOutput("ill_err1", err, 1);
    checkWordlines("ill_load1", 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1'b0, 25'd0);
    checkOutput("ill_err1_end", err, 0);
    tick();
    checkOutput("ill_err2", err, 1);
    tick();
    checkOutput("ill_err2_end", err, 0);
    tick();
    checkOutput("xor_load_err", err, 0);
    tick();
    checkWordlines("xor_exec", oh(7), oh(8), 0, oh(12), 0);
    checkOutput("xor_done", done, 1);
    tick();
    checkOutput("xor_end_busy", busy, 0);
    checkOutput("xor_end_done", done, 0);

    // ADD: odd-address partner rows on channel 3 / write channel 2
    applyStimulus(1'b1, mk_cmd(M_ADD, 3'd0, 2, 4, 10));
    tick();
    applyStimulus(1'b0, 25'd0);
    tick();
    tick();
    checkWordlines("add_exec", oh(2), oh(4), oh(5), oh(10), oh(11));
    checkOutput("add_done", done, 1);
    tick();
    checkWordlines("add_end", 0, 0, 0, 0, 0);
    checkOutput("add_end_done", done, 0);

    // Long MUL interrupted by reset at iteration 17, with an AND queued behind it
    applyStimulus(1'b1, mk_cmd(M_MUL, 3'd5, 3, 5, 9));
    tick();
    applyStimulus(1'b1, mk_cmd(M_AND, 3'd0, 40, 41, 42));
    tick();
    applyStimulus(1'b0, 25'd0);
    repeat (18) tick();
    checkOutput("mul64_iter17", cur_iter, 17);
    checkWordlines("mul64_k17", oh(62), oh(5), oh(63), oh(9), oh(3));
    rst_n = 1'b0;
    #1;
    checkWordlines("mid_rst", 0, 0, 0, 0, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ready", cmd_ready, 1);
    checkOutput("mid_rst_iter", cur_iter, 0);
    checkOutput("mid_rst_done", done, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rst_hold_done", done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("post_rst_busy", busy, 0);
      checkOutput("post_rst_done", done, 0);
    end

    // SHIFT after reset recovery
    applyStimulus(1'b1, mk_cmd(M_SHIFT, 3'd4, 20, 7, 33));
    tick();
    applyStimulus(1'b0, 25'd0);
    checkOutput("shift_busy", busy, 1);
    tick();
    tick();
    checkWordlines("shift_exec", 0, 0, oh(20), 0, oh(33));
    checkOutput("shift_done", done, 1);
    tick();
    checkOutput("shift_end_done", done, 0);
    checkOutput("shift_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
